// File: rtl/plab4_net_router_multidom.sv
// rtl/plab4_net_router_multidom.sv - ring router with per-domain input queues and round-robin outputs
// Optional time-division domain gating: define PLAB4_NET_ROUTER_TDM_EN
module plab4_net_router_multidom #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_num_domains   = 2,
  parameter int p_queue_depth   = 8,
  parameter int p_epoch         = 4,
  localparam int N = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits,
  localparam int D = ($clog2(p_num_domains) > 1) ? $clog2(p_num_domains) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in0_val,
  output logic           in0_rdy,
  input  logic [N+D-1:0] in0_msg,
  input  logic           in1_val,
  output logic           in1_rdy,
  input  logic [N+D-1:0] in1_msg,
  input  logic           in_ter_val,
  output logic           in_ter_rdy,
  input  logic [N-1:0]   in_ter_msg,
  input  logic [D-1:0]   in_ter_dom,
  output logic           out0_val,
  input  logic           out0_rdy,
  output logic [N+D-1:0] out0_msg,
  output logic           out1_val,
  input  logic           out1_rdy,
  output logic [N+D-1:0] out1_msg,
  output logic           out_ter_val,
  input  logic           out_ter_rdy,
  output logic [N-1:0]   out_ter_msg,
  output logic [D-1:0]   out_ter_dom
);
  localparam int NI = 3;
  localparam int ND = p_num_domains;
  localparam int Q  = p_queue_depth;
  localparam int PW = $clog2(Q);
  localparam int CW = PW + 1;
  localparam int SW = p_srcdest_nbits;

  if (ND < 2 || ND > 8 || Q < 2 || (Q & (Q - 1)) != 0 || p_epoch < 1) begin : g_bad_cfg
    $error("plab4_net_router_multidom: unsupported parameter set");
  end

  // Port index: 0 = in0/out0 (west), 1 = terminal, 2 = in1/out1 (east)
  logic [N-1:0]  mem  [NI][ND][Q];
  logic [PW-1:0] wp   [NI][ND];
  logic [PW-1:0] rp   [NI][ND];
  logic [CW-1:0] cnt  [NI][ND];
  logic [D-1:0]  dptr [NI];
  logic [1:0]    optr [NI];

  logic [NI-1:0] ival, irdy, iget, sval, deq, oval, ordy, ogo;
  logic [D-1:0]  idom [NI];
  logic [N-1:0]  imsg [NI];
  logic [D-1:0]  sdom [NI];
  logic [N-1:0]  smsg [NI];
  logic [1:0]    sout [NI];
  logic [1:0]    owin [NI];
  logic          enq_hit [NI][ND];
  logic          deq_hit [NI][ND];
  logic [ND-1:0] dom_en;

  assign ival    = {in1_val, in_ter_val, in0_val};
  assign ordy    = {out1_rdy, out_ter_rdy, out0_rdy};
  assign idom[0] = in0_msg[N+D-1 -: D];
  assign imsg[0] = in0_msg[N-1:0];
  assign idom[1] = in_ter_dom;
  assign imsg[1] = in_ter_msg;
  assign idom[2] = in1_msg[N+D-1 -: D];
  assign imsg[2] = in1_msg[N-1:0];
  assign {in1_rdy, in_ter_rdy, in0_rdy} = irdy;

`ifdef PLAB4_NET_ROUTER_TDM_EN
  localparam int EW = (p_epoch > 1) ? $clog2(p_epoch) : 1;
  logic [EW-1:0] tdm_cnt;
  logic [D-1:0]  tdm_slot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tdm_cnt  <= '0;
      tdm_slot <= '0;
    end else if (int'(tdm_cnt) == p_epoch - 1) begin
      tdm_cnt  <= '0;
      tdm_slot <= (int'(tdm_slot) == ND - 1) ? '0 : tdm_slot + D'(1);
    end else begin
      tdm_cnt <= tdm_cnt + EW'(1);
    end
  end

  always_comb begin
    dom_en = '0;
    for (int d = 0; d < ND; d++) dom_en[d] = (int'(tdm_slot) == d);
  end
`else
  assign dom_en = '1;
`endif

  // Unknown domains are acknowledged and silently dropped
  always_comb begin
    irdy = '0;
    iget = '0;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        if (int'(idom[i]) >= ND) begin
          irdy[i] = 1'b1;
        end else begin
          irdy[i] = int'(cnt[i][idom[i]]) != Q;
          iget[i] = ival[i] && irdy[i];
        end
      end
    end
  end

  // Per input: first eligible domain head from the rotating pointer, plus its route
  always_comb begin
    int d, dest, east, west, r;
    logic ok;
    logic [N-1:0] head;
    sval = '0;
    for (int i = 0; i < NI; i++) begin
      sdom[i] = '0;
      smsg[i] = '0;
      sout[i] = 2'd0;
      for (int k = 0; k < ND; k++) begin
        d    = (int'(dptr[i]) + k) % ND;
        head = mem[i][d][rp[i][d]];
        dest = int'(head[N-1 -: SW]);
        east = (dest - p_router_id + p_num_routers) % p_num_routers;
        west = (p_router_id - dest + p_num_routers) % p_num_routers;
        if (dest == p_router_id) r = 1;
        else if (i == 0)         r = 2;
        else if (i == 2)         r = 0;
        else                     r = (east <= west) ? 2 : 0;
        ok = (cnt[i][d] != '0) && dom_en[d];
        // Injection must leave a bubble in the ring queue it competes with
        if (i == 1 && r == 2) ok = ok && (Q - int'(cnt[0][d]) >= 2);
        if (i == 1 && r == 0) ok = ok && (Q - int'(cnt[2][d]) >= 2);
        if (ok && !sval[i]) begin
          sval[i] = 1'b1;
          sdom[i] = D'(d);
          smsg[i] = head;
          sout[i] = 2'(r);
        end
      end
    end
  end

  always_comb begin
    int j;
    oval = '0;
    ogo  = '0;
    deq  = '0;
    for (int o = 0; o < NI; o++) begin
      owin[o] = 2'd0;
      for (int k = 0; k < NI; k++) begin
        j = (int'(optr[o]) + k) % NI;
        if (!oval[o] && sval[j] && int'(sout[j]) == o) begin
          oval[o] = 1'b1;
          owin[o] = 2'(j);
        end
      end
      ogo[o] = oval[o] && ordy[o] && reset;
    end
    for (int i = 0; i < NI; i++) begin
      deq[i] = sval[i] && ogo[sout[i]] && int'(owin[sout[i]]) == i;
      for (int d = 0; d < ND; d++) begin
        enq_hit[i][d] = iget[i] && int'(idom[i]) == d;
        deq_hit[i][d] = deq[i] && int'(sdom[i]) == d;
      end
    end
  end

  assign out0_val    = oval[0] && reset;
  assign out0_msg    = {sdom[owin[0]], smsg[owin[0]]};
  assign out_ter_val = oval[1] && reset;
  assign out_ter_msg = smsg[owin[1]];
  assign out_ter_dom = sdom[owin[1]];
  assign out1_val    = oval[2] && reset;
  assign out1_msg    = {sdom[owin[2]], smsg[owin[2]]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        dptr[i] <= '0;
        optr[i] <= '0;
        for (int d = 0; d < ND; d++) begin
          wp[i][d]  <= '0;
          rp[i][d]  <= '0;
          cnt[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        for (int d = 0; d < ND; d++) begin
          if (enq_hit[i][d]) begin
            mem[i][d][wp[i][d]] <= imsg[i];
            wp[i][d] <= wp[i][d] + PW'(1);
          end
          if (deq_hit[i][d]) rp[i][d] <= rp[i][d] + PW'(1);
          if (enq_hit[i][d] && !deq_hit[i][d])      cnt[i][d] <= cnt[i][d] + CW'(1);
          else if (!enq_hit[i][d] && deq_hit[i][d]) cnt[i][d] <= cnt[i][d] - CW'(1);
        end
        if (deq[i]) dptr[i] <= D'((int'(sdom[i]) + 1) % ND);
        if (ogo[i]) optr[i] <= 2'((int'(owin[i]) + 1) % NI);
      end
    end
  end
endmodule

// File: tb/tb_plab4_net_router_multidom.sv
// tb/tb_plab4_net_router_multidom.sv - directed checks for the multi-domain ring router (router id 2 of 8)
module tb_plab4_net_router_multidom;
  localparam int N = 41;
  localparam int D = 1;

  logic clk = 1'b0;
  logic reset;
  logic in0_val, in0_rdy, in1_val, in1_rdy, in_ter_val, in_ter_rdy;
  logic [N+D-1:0] in0_msg, in1_msg, out0_msg, out1_msg;
  logic [N-1:0] in_ter_msg, out_ter_msg;
  logic [D-1:0] in_ter_dom, out_ter_dom;
  logic out0_val, out0_rdy, out1_val, out1_rdy, out_ter_val, out_ter_rdy;

  int checks = 0;
  int failures = 0;

  plab4_net_router_multidom #(.p_router_id(2)) dut (
    .clk(clk), .reset(reset),
    .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg),
    .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg),
    .in_ter_val(in_ter_val), .in_ter_rdy(in_ter_rdy), .in_ter_msg(in_ter_msg), .in_ter_dom(in_ter_dom),
    .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg),
    .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg),
    .out_ter_val(out_ter_val), .out_ter_rdy(out_ter_rdy), .out_ter_msg(out_ter_msg), .out_ter_dom(out_ter_dom)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mk(input int dest, input int src, input int pay);
    return {3'(dest), 3'(src), 3'b000, 32'(pay)};
  endfunction

  initial begin
    reset = 1'b0;
    in0_val = 1'b1; in0_msg = {1'b0, mk(2, 1, 1)};
    in1_val = 1'b0; in1_msg = '0;
    in_ter_val = 1'b0; in_ter_msg = '0; in_ter_dom = '0;
    out0_rdy = 1'b1; out1_rdy = 1'b1; out_ter_rdy = 1'b1;

    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_out0_val", out0_val, 0);
      check("rst_out1_val", out1_val, 0);
      check("rst_ter_val", out_ter_val, 0);
      check("rst_in0_rdy", in0_rdy, 0);
      check("rst_in1_rdy", in1_rdy, 0);
      check("rst_ter_rdy", in_ter_rdy, 0);
    end
    reset = 1'b1;
    in0_val = 1'b0;
    #1;
    check("post_out0_val", out0_val, 0);
    check("post_out1_val", out1_val, 0);
    check("post_ter_val", out_ter_val, 0);
    check("post_in0_rdy", in0_rdy, 1);

`ifdef PLAB4_NET_ROUTER_TDM_EN
    in1_val = 1'b1; in1_msg = {1'b1, mk(2, 1, 'h11)};
    step();
    in1_val = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check("tdm_d1_wait", out_ter_val, 0);
      step();
    end
    check("tdm_d1_val", out_ter_val, 1);
    check("tdm_d1_dom", out_ter_dom, 1);
    check("tdm_d1_msg", out_ter_msg, mk(2, 1, 'h11));
    in0_val = 1'b1; in0_msg = {1'b0, mk(2, 3, 'h22)};
    step();
    in0_val = 1'b0;
    for (int c = 5; c < 8; c++) begin
      check("tdm_d0_wait", out_ter_val, 0);
      step();
    end
    check("tdm_d0_val", out_ter_val, 1);
    check("tdm_d0_msg", out_ter_msg, mk(2, 3, 'h22));
`else
    begin
      logic [N+D-1:0] m;
      logic [N-1:0] e;
      m = {1'b1, mk(5, 1, 'h55)};
      in0_val = 1'b1; in0_msg = m;
      #1;
      check("pt_rdy", in0_rdy, 1);
      check("pt_nobypass", out1_val, 0);
      step();
      in0_val = 1'b0;
      check("pt_val", out1_val, 1);
      check("pt_msg", out1_msg, m);
      check("pt_ter_idle", out_ter_val, 0);
      step();
      check("pt_gone", out1_val, 0);

      out_ter_rdy = 1'b0;
      in1_val = 1'b1;
      for (int k = 0; k < 8; k++) begin
        in1_msg = {1'b0, mk(2, 3, k)};
        #1;
        check("full_fill_rdy", in1_rdy, 1);
        step();
      end
      in1_msg = {1'b0, mk(2, 3, 99)};
      #1;
      check("full_rdy_d0", in1_rdy, 0);
      in1_msg = {1'b1, mk(2, 3, 98)};
      #1;
      check("full_rdy_d1", in1_rdy, 1);
      in1_val = 1'b0;
      check("full_ter_val", out_ter_val, 1);
      check("full_ter_dom", out_ter_dom, 0);
      out_ter_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
        #1;
        check("full_drain", out_ter_msg, mk(2, 3, k));
        step();
      end
      check("full_empty", out_ter_val, 0);

      for (int s = 0; s < 12; s++) begin
        if (s < 6) begin
          in0_val = 1'b1; in0_msg = {1'b0, mk(2, 0, 'h100 + s)};
          in1_val = 1'b1; in1_msg = {1'b0, mk(2, 4, 'h200 + s)};
        end else begin
          in0_val = 1'b0;
          in1_val = 1'b0;
        end
        step();
        e = (s % 2 == 0) ? mk(2, 0, 'h100 + s / 2) : mk(2, 4, 'h200 + s / 2);
        check("rr_val", out_ter_val, 1);
        check("rr_msg", out_ter_msg, e);
      end
      in0_val = 1'b0;
      in1_val = 1'b0;
      step();
      check("rr_empty", out_ter_val, 0);

      in1_val = 1'b1; in1_msg = {1'b1, mk(2, 6, 'h77)};
      step();
      in1_val = 1'b0;
      check("d1_val", out_ter_val, 1);
      check("d1_dom", out_ter_dom, 1);
      check("d1_msg", out_ter_msg, mk(2, 6, 'h77));
      step();
      check("d1_gone", out_ter_val, 0);

      out1_rdy = 1'b0;
      in0_val = 1'b1;
      for (int k = 0; k < 7; k++) begin
        in0_msg = {1'b0, mk(5, 1, 'h300 + k)};
        step();
      end
      in0_val = 1'b0;
      in_ter_val = 1'b1; in_ter_dom = 1'b0; in_ter_msg = mk(3, 2, 'h400);
      #1;
      check("thr_ter_rdy", in_ter_rdy, 1);
      step();
      in_ter_val = 1'b0;
      check("thr_head_stall", out1_msg, {1'b0, mk(5, 1, 'h300)});
      out1_rdy = 1'b1;
      #1;
      check("thr_blocked", out1_msg, {1'b0, mk(5, 1, 'h300)});
      step();
      check("thr_granted", out1_msg, {1'b0, mk(3, 2, 'h400)});
      check("thr_out0_idle", out0_val, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
